// File: rtl/chg_pkg.sv
// Shared types and widths for the change-record dispatcher.
package chg_pkg;

   localparam int ROW_W = 16;
   localparam int COL_W = 16;
   localparam int VAL_W = 24;
   localparam int Y_W   = 48;

   // One change record as it travels through the FIFO and hold registers.
   typedef struct packed {
      logic        [ROW_W-1:0] row;
      logic        [COL_W-1:0] col;
      logic signed [VAL_W-1:0] re;
      logic signed [VAL_W-1:0] im;
   } chg_rec_t;

   localparam int REC_W = $bits(chg_rec_t);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESULT
   } chg_state_t;

endpackage

// File: rtl/chg_dispatch_if.sv
// Record input, core launch/return and result output bundle for chg_dispatch.
interface chg_dispatch_if #(
   parameter int CNT_W = 16
);
   import chg_pkg::*;

   // Incoming change records
   logic             in_valid;
   logic             in_ready;
   logic [ROW_W-1:0] in_row;
   logic [COL_W-1:0] in_col;
   logic [VAL_W-1:0] in_real;
   logic [VAL_W-1:0] in_img;

   // Integration core launch and return
   logic             core_start;
   logic [ROW_W-1:0] core_row;
   logic [COL_W-1:0] core_col;
   logic [VAL_W-1:0] core_real;
   logic [VAL_W-1:0] core_img;
   logic             core_done;
   logic [Y_W-1:0]   core_yval;

   // Result stream and status
   logic             out_valid;
   logic             out_ready;
   logic [Y_W-1:0]   out_yval;
   logic [ROW_W-1:0] out_row;
   logic [COL_W-1:0] out_col;
   logic             out_timeout;
   logic             busy;
   logic [CNT_W-1:0] done_count;

   // Dispatcher side
   modport slave (
      input  in_valid, in_row, in_col, in_real, in_img,
      input  core_done, core_yval, out_ready,
      output in_ready, core_start, core_row, core_col, core_real, core_img,
      output out_valid, out_yval, out_row, out_col, out_timeout, busy, done_count
   );

   // Producer / core / consumer side
   modport master (
      output in_valid, in_row, in_col, in_real, in_img,
      output core_done, core_yval, out_ready,
      input  in_ready, core_start, core_row, core_col, core_real, core_img,
      input  out_valid, out_yval, out_row, out_col, out_timeout, busy, done_count
   );

endinterface

// File: rtl/chg_fifo.sv
// Small record FIFO; pointers carry one extra wrap bit to tell full from empty.
module chg_fifo
   import chg_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     push,
   input  chg_rec_t pushData,
   output logic     full,
   input  logic     pop,
   output chg_rec_t popData,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   chg_rec_t      mem [DEPTH];
   logic [AW:0]   wrPtr;
   logic [AW:0]   rdPtr;
   logic          doPush;
   logic          doPop;

   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign empty   = (wrPtr == rdPtr);
   assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign popData = mem[rdPtr[AW-1:0]];

   // Advance read/write pointers; reset empties the queue.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   // Record storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clock) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/chg_dispatch.sv
// Buffers change records and issues them one at a time to the Y-integration core,
// returning the core result (or a timeout marker) on a valid/ready port.
module chg_dispatch
   import chg_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic          clock,
   input  logic          reset,
   chg_dispatch_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   chg_state_t       state;
   chg_state_t       nextState;
   chg_rec_t         inRec;
   chg_rec_t         headRec;
   chg_rec_t         holdRec;
   logic             fifoFull;
   logic             fifoEmpty;
   logic             fifoPop;
   logic             inReady;
   logic             pushReq;
   logic             captureDone;
   logic             captureTimeout;
   logic             accept;
   logic             timeoutHit;
   logic [CW-1:0]    waitCnt;
   logic [Y_W-1:0]   outYval;
   logic [ROW_W-1:0] outRow;
   logic [COL_W-1:0] outCol;
   logic             outTimeout;
   logic [CNT_W-1:0] doneCount;

   // Saturating increment for the processed-record counter.
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign inRec      = '{row: bus.in_row, col: bus.in_col, re: bus.in_real, im: bus.in_img};
   assign inReady    = !fifoFull && !reset;
   assign pushReq    = bus.in_valid && inReady;
   assign timeoutHit = (waitCnt == CW'(TIMEOUT - 1));

   chg_fifo #(.DEPTH(DEPTH)) uFifo (
      .clock    (clock),
      .reset    (reset),
      .push     (pushReq),
      .pushData (inRec),
      .full     (fifoFull),
      .pop      (fifoPop),
      .popData  (headRec),
      .empty    (fifoEmpty)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state decode: done beats the timeout boundary; core_done elsewhere is ignored.
   always_comb begin
      nextState      = state;
      fifoPop        = 1'b0;
      captureDone    = 1'b0;
      captureTimeout = 1'b0;
      accept         = 1'b0;
      case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               fifoPop   = 1'b1;
               nextState = ISSUE;
            end
         end
         ISSUE: nextState = WAIT;
         WAIT: begin
            if (bus.core_done) begin
               captureDone = 1'b1;
               nextState   = RESULT;
            end else if (timeoutHit) begin
               captureTimeout = 1'b1;
               nextState      = RESULT;
            end
         end
         RESULT: begin
            if (bus.out_ready) begin
               accept    = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Hold the popped record for the core until the next pop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)        holdRec <= '0;
      else if (fifoPop) holdRec <= headRec;
   end

   // Cycles spent waiting on the core, cleared on launch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)               waitCnt <= '0;
      else if (state == ISSUE) waitCnt <= '0;
      else if (state == WAIT)  waitCnt <= waitCnt + 1'b1;
   end

   // Capture the result presented while in RESULT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outYval    <= '0;
         outRow     <= '0;
         outCol     <= '0;
         outTimeout <= 1'b0;
      end else if (captureDone || captureTimeout) begin
         outYval    <= captureDone ? bus.core_yval : '0;
         outRow     <= holdRec.row;
         outCol     <= holdRec.col;
         outTimeout <= captureTimeout;
      end
   end

   // Count accepted results.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       doneCount <= '0;
      else if (accept) doneCount <= satInc(doneCount);
   end

   assign bus.in_ready    = inReady;
   assign bus.core_start  = (state == ISSUE);
   assign bus.core_row    = holdRec.row;
   assign bus.core_col    = holdRec.col;
   assign bus.core_real   = holdRec.re;
   assign bus.core_img    = holdRec.im;
   assign bus.out_valid   = (state == RESULT);
   assign bus.out_yval    = outYval;
   assign bus.out_row     = outRow;
   assign bus.out_col     = outCol;
   assign bus.out_timeout = outTimeout;
   assign bus.busy        = (state != IDLE) || !fifoEmpty;
   assign bus.done_count  = doneCount;

endmodule

// File: tb/tb_chg_dispatch.sv
// Directed bench for chg_dispatch with a behavioural core and a result scoreboard.
module tb_chg_dispatch;
   import chg_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int CNT_W   = 16;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   chg_dispatch_if #(.CNT_W(CNT_W)) bus ();

   chg_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [47:0] yval;
      logic [15:0] row;
      logic [15:0] col;
      logic        tmo;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          startCount = 0;
   int          resCount = 0;
   int          lastStartCyc = 0;
   int          lastRiseCyc = 0;
   int          lastPushCyc = 0;
   int          coreDelay = 0;
   int          cd = 0;
   logic        yvalSel = 1'b0;
   logic [47:0] fixedYval = 48'h123456abcdef;
   logic [47:0] modelYval = '0;
   logic        modelDone = 1'b0;
   logic        manualDone = 1'b0;
   logic [47:0] manualYval = '0;
   logic        prevValid = 1'b0;
   int          s0, r0, p;

   assign bus.core_done = modelDone | manualDone;
   assign bus.core_yval = manualDone ? manualYval : modelYval;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] modelY(input logic [15:0] r, input logic [15:0] c,
                                          input logic [23:0] re);
      return {r, c, re[15:0]};
   endfunction

   always @(posedge clock) cyc++;

   // Behavioural core: done pulses coreDelay negedges after start (0 = never).
   always @(negedge clock) begin
      modelDone = 1'b0;
      if (reset) cd = 0;
      else begin
         if (cd > 0) begin
            cd--;
            if (cd == 0) modelDone = 1'b1;
         end
         if (bus.core_start) begin
            startCount++;
            lastStartCyc = cyc;
            if (coreDelay > 0) cd = coreDelay;
            modelYval = yvalSel ? fixedYval : modelY(bus.core_row, bus.core_col, bus.core_real);
         end
      end
   end

   // Result monitor: every accepted result is popped from the scoreboard and compared.
   always @(negedge clock) begin
      exp_t e;
      #2;
      if (bus.out_valid && !prevValid) lastRiseCyc = cyc;
      prevValid = bus.out_valid;
      if (bus.out_valid && bus.out_ready && !reset) begin
         if (sb.size() == 0) chk("unexpected_result", bus.out_valid, 0);
         else begin
            e = sb.pop_front();
            chk("out_yval", bus.out_yval, e.yval);
            chk("out_row", bus.out_row, e.row);
            chk("out_col", bus.out_col, e.col);
            chk("out_timeout", bus.out_timeout, e.tmo);
         end
         resCount++;
      end
   end

   // Offer one record; called and returning aligned to a falling edge.
   task automatic pushRec(input logic [15:0] r, input logic [15:0] c, input logic [23:0] re,
                          input logic [23:0] im, input bit track, input bit tmo,
                          input logic [47:0] yv);
      int tries = 0;
      bus.in_valid = 1'b1;
      bus.in_row   = r;
      bus.in_col   = c;
      bus.in_real  = re;
      bus.in_img   = im;
      #1;
      while (!bus.in_ready && tries < 200) begin
         @(negedge clock);
         #1;
         tries++;
      end
      if (!bus.in_ready) chk("push_accept", bus.in_ready, 1);
      else begin
         lastPushCyc = cyc + 1;
         if (track) sb.push_back('{yval: (tmo ? 48'h0 : yv), row: r, col: c, tmo: tmo});
      end
      @(negedge clock);
      bus.in_valid = 1'b0;
   endtask

   task automatic waitRes(input int n, input int budget);
      int k = 0;
      @(negedge clock);
      #3;
      while (resCount < n && k < budget) begin
         @(negedge clock);
         #3;
         k++;
      end
      chk("results_seen", resCount, n);
      @(negedge clock);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_row = '0; bus.in_col = '0; bus.in_real = '0; bus.in_img = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_core_start", bus.core_start, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done_count", bus.done_count, 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("in_ready_release", bus.in_ready, 1);

      // Single record with fixed core value
      @(negedge clock);
      coreDelay = 3; yvalSel = 1'b1; bus.out_ready = 1'b1; s0 = startCount;
      pushRec(16'h0000, 16'h0010, 24'h4ebd90, 24'h5c2e27, 1, 0, fixedYval);
      p = lastPushCyc;
      waitRes(1, 50);
      #1;
      chk("t1_starts", startCount - s0, 1);
      chk("t1_start_cyc", lastStartCyc, p + 1);
      chk("t1_valid_cyc", lastRiseCyc, p + 5);
      chk("t1_core_row", bus.core_row, 16'h0000);
      chk("t1_core_col", bus.core_col, 16'h0010);
      chk("t1_core_real", bus.core_real, 24'h4ebd90);
      chk("t1_core_img", bus.core_img, 24'h5c2e27);
      chk("t1_done_count", bus.done_count, 1);

      // Fill and backpressure
      @(negedge clock);
      yvalSel = 1'b0; coreDelay = 1; bus.out_ready = 1'b0; s0 = startCount; r0 = resCount;
      for (int i = 0; i < 5; i++) begin
         logic [15:0] rr, cc;
         logic [23:0] re;
         rr = 16'h0100 + 16'(i); cc = 16'h0200 + 16'(i); re = 24'h0a0000 + 24'(i * 17);
         pushRec(rr, cc, re, 24'h00f000 + 24'(i), 1, 0, modelY(rr, cc, re));
      end
      #1;
      chk("t2_full_in_ready", bus.in_ready, 0);
      chk("t2_busy", bus.busy, 1);
      @(negedge clock);
      bus.in_valid = 1'b1; bus.in_row = 16'h0105; bus.in_col = 16'h0205;
      bus.in_real = 24'h0a0055; bus.in_img = 24'h00f005;
      repeat (5) @(negedge clock);
      #1;
      chk("t2_blocked_in_ready", bus.in_ready, 0);
      chk("t2_result_held", bus.out_valid, 1);
      @(negedge clock);
      bus.out_ready = 1'b1;
      pushRec(16'h0105, 16'h0205, 24'h0a0055, 24'h00f005, 1, 0,
              modelY(16'h0105, 16'h0205, 24'h0a0055));
      waitRes(r0 + 6, 200);
      #1;
      chk("t2_starts", startCount - s0, 6);
      chk("t2_done_count", bus.done_count, 7);

      // Timeout, then a normal record
      @(negedge clock);
      coreDelay = 0; r0 = resCount;
      pushRec(16'h0300, 16'h0301, 24'h000001, 24'h000002, 1, 1, '0);
      p = lastPushCyc;
      waitRes(r0 + 1, 150);
      #1;
      chk("t3_valid_cyc", lastRiseCyc, p + 2 + TIMEOUT);
      @(negedge clock);
      coreDelay = 2;
      pushRec(16'h0310, 16'h0311, 24'h7abcde, 24'h123456, 1, 0,
              modelY(16'h0310, 16'h0311, 24'h7abcde));
      waitRes(r0 + 2, 50);

      // Done exactly on the timeout boundary wins; done one cycle late is ignored
      coreDelay = TIMEOUT;
      pushRec(16'h0400, 16'h0401, 24'h00beef, 24'h000003, 1, 0,
              modelY(16'h0400, 16'h0401, 24'h00beef));
      p = lastPushCyc;
      waitRes(r0 + 3, 150);
      #1;
      chk("t4_valid_cyc", lastRiseCyc, p + 2 + TIMEOUT);
      @(negedge clock);
      coreDelay = TIMEOUT + 1;
      pushRec(16'h0410, 16'h0411, 24'h00cafe, 24'h000004, 1, 1, '0);
      waitRes(r0 + 4, 150);
      #1;
      chk("t4_done_count", bus.done_count, 11);

      // Spurious done in IDLE and in RESULT
      @(negedge clock);
      r0 = resCount; s0 = startCount;
      manualYval = 48'hdeadbeef0001; manualDone = 1'b1;
      @(negedge clock);
      manualDone = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("t5_idle_valid", bus.out_valid, 0);
      chk("t5_idle_busy", bus.busy, 0);
      chk("t5_idle_starts", startCount - s0, 0);
      @(negedge clock);
      bus.out_ready = 1'b0; coreDelay = 1;
      pushRec(16'h0500, 16'h0501, 24'h055555, 24'h066666, 1, 0,
              modelY(16'h0500, 16'h0501, 24'h055555));
      repeat (4) @(negedge clock);
      manualDone = 1'b1;
      @(negedge clock);
      manualDone = 1'b0;
      #1;
      chk("t5_result_valid", bus.out_valid, 1);
      chk("t5_result_yval", bus.out_yval, modelY(16'h0500, 16'h0501, 24'h055555));
      @(negedge clock);
      bus.out_ready = 1'b1;
      waitRes(r0 + 1, 50);
      #1;
      chk("t5_done_count", bus.done_count, 12);

      // Reset while waiting with two records queued
      @(negedge clock);
      coreDelay = 0;
      pushRec(16'h0600, 16'h0601, 24'h000011, 24'h000012, 0, 0, '0);
      pushRec(16'h0610, 16'h0611, 24'h000021, 24'h000022, 0, 0, '0);
      pushRec(16'h0620, 16'h0621, 24'h000031, 24'h000032, 0, 0, '0);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("t6_in_ready", bus.in_ready, 0);
      chk("t6_core_start", bus.core_start, 0);
      chk("t6_core_row", bus.core_row, 0);
      chk("t6_core_real", bus.core_real, 0);
      chk("t6_out_valid", bus.out_valid, 0);
      chk("t6_out_yval", bus.out_yval, 0);
      chk("t6_out_row", bus.out_row, 0);
      chk("t6_out_col", bus.out_col, 0);
      chk("t6_busy", bus.busy, 0);
      chk("t6_done_count", bus.done_count, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      r0 = resCount; s0 = startCount;
      repeat (10) @(negedge clock);
      #1;
      chk("t6_post_valid", bus.out_valid, 0);
      chk("t6_post_busy", bus.busy, 0);
      chk("t6_post_starts", startCount - s0, 0);
      @(negedge clock);
      coreDelay = 2;
      pushRec(16'h0700, 16'h0701, 24'h071234, 24'h075678, 1, 0,
              modelY(16'h0700, 16'h0701, 24'h071234));
      waitRes(r0 + 1, 50);
      #1;
      chk("t6_restart_count", bus.done_count, 1);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
